disp_scheduler: RTL and testbench

DISP_SCHEDULER -- requirements
Module: disp_scheduler

---
 rtl/disp_scheduler.sv | 155 +++++++++++++++
 tb/tb_disp_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scheduler.sv
// Display message scheduler: chooses between the number and timed ERR/OP/VAL
// messages, holding timed messages for HOLD_CYCLES with a one-deep pending prompt.
module disp_scheduler #(
    parameter int unsigned HOLD_CYCLES = 32'd50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       num_we,
    input  logic [7:0] bin_in,
    input  logic       sgn_in,
    input  logic [1:0] dot_in,
    input  logic       err_req,
    input  logic       prompt_req,
    input  logic       prompt_sel,
    output logic [1:0] msg,
    output logic [7:0] bin,
    output logic       sgn,
    output logic [1:0] dot,
    output logic       busy,
    output logic       msg_done
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 32'd1);

    localparam logic [1:0] S_NUM    = 2'd0;
    localparam logic [1:0] S_PROMPT = 2'd1;
    localparam logic [1:0] S_ERR    = 2'd2;

    localparam logic [1:0] MSG_NUM = 2'b00;
    localparam logic [1:0] MSG_OP  = 2'b01;
    localparam logic [1:0] MSG_VAL = 2'b10;
    localparam logic [1:0] MSG_ERR = 2'b11;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             cur_sel;
    logic             pend_v;
    logic             pend_sel;

    logic [1:0]       nxt_state;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_sel;
    logic             nxt_pend_v;
    logic             nxt_pend_sel;
    logic             nxt_done;
    logic [7:0]       nxt_bin;
    logic             nxt_sgn;
    logic [1:0]       nxt_dot;
    logic [1:0]       nxt_msg;

    // State, counter, pending prompt and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_NUM;
            cnt      <= '0;
            cur_sel  <= 1'b0;
            pend_v   <= 1'b0;
            pend_sel <= 1'b0;
            msg      <= MSG_NUM;
            bin      <= '0;
            sgn      <= 1'b0;
            dot      <= '0;
            busy     <= 1'b0;
            msg_done <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            cur_sel  <= nxt_sel;
            pend_v   <= nxt_pend_v;
            pend_sel <= nxt_pend_sel;
            msg      <= nxt_msg;
            bin      <= nxt_bin;
            sgn      <= nxt_sgn;
            dot      <= nxt_dot;
            busy     <= (nxt_state != S_NUM);
            msg_done <= nxt_done;
        end
    end

    // Next-state logic: clr > err_req > prompt_req; number load is independent
    always_comb begin
        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_sel      = cur_sel;
        nxt_pend_v   = pend_v;
        nxt_pend_sel = pend_sel;
        nxt_done     = 1'b0;
        nxt_bin      = bin;
        nxt_sgn      = sgn;
        nxt_dot      = dot;

        if (num_we) begin
            nxt_bin = bin_in;
            nxt_sgn = sgn_in;
            nxt_dot = dot_in;
        end

        if (clr) begin
            nxt_bin      = '0;
            nxt_sgn      = 1'b0;
            nxt_dot      = '0;
            nxt_state    = S_NUM;
            nxt_cnt      = '0;
            nxt_pend_v   = 1'b0;
            nxt_pend_sel = 1'b0;
        end else if (err_req) begin
            nxt_state = S_ERR;
            nxt_cnt   = CNT_LOAD;
            if (prompt_req) begin
                nxt_pend_v   = 1'b1;
                nxt_pend_sel = prompt_sel;
            end
        end else if (prompt_req && (state != S_ERR)) begin
            nxt_state = S_PROMPT;
            nxt_sel   = prompt_sel;
            nxt_cnt   = CNT_LOAD;
        end else begin
            // A prompt arriving during ERR is queued; it may be consumed by this same expiry
            if (prompt_req) begin
                nxt_pend_v   = 1'b1;
                nxt_pend_sel = prompt_sel;
            end
            if (state != S_NUM) begin
                if (cnt == '0) begin
                    nxt_done = 1'b1;
                    if ((state == S_ERR) && nxt_pend_v) begin
                        nxt_state    = S_PROMPT;
                        nxt_sel      = nxt_pend_sel;
                        nxt_cnt      = CNT_LOAD;
                        nxt_pend_v   = 1'b0;
                        nxt_pend_sel = 1'b0;
                    end else begin
                        nxt_state = S_NUM;
                        nxt_cnt   = '0;
                    end
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end
        end
    end

    // Message code for the decoder, derived from the upcoming state
    always_comb begin
        nxt_msg = MSG_NUM;
        if (nxt_state == S_ERR) begin
            nxt_msg = MSG_ERR;
        end else if (nxt_state == S_PROMPT) begin
            nxt_msg = nxt_sel ? MSG_VAL : MSG_OP;
        end
    end

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler (HOLD_CYCLES = 4): directed scenarios plus random
// traffic compared against a message/remaining-time reference model.
module tb_disp_scheduler;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       num_we = 1'b0;
    logic [7:0] bin_in = '0;
    logic       sgn_in = 1'b0;
    logic [1:0] dot_in = '0;
    logic       err_req = 1'b0;
    logic       prompt_req = 1'b0;
    logic       prompt_sel = 1'b0;
    logic [1:0] msg;
    logic [7:0] bin;
    logic       sgn;
    logic [1:0] dot;
    logic       busy;
    logic       msg_done;

    int checks = 0;
    int errors = 0;

    // Reference model: message shown (0 num, 1 OP, 2 VAL, 3 ERR) and cycles left
    int         m_kind = 0;
    int         m_rem = 0;
    bit         m_pend = 0;
    bit         m_psel = 0;
    bit         m_done = 0;
    logic [7:0] m_bin = '0;
    logic       m_sgn = 1'b0;
    logic [1:0] m_dot = '0;

    disp_scheduler #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .clr(clr), .num_we(num_we),
        .bin_in(bin_in), .sgn_in(sgn_in), .dot_in(dot_in),
        .err_req(err_req), .prompt_req(prompt_req), .prompt_sel(prompt_sel),
        .msg(msg), .bin(bin), .sgn(sgn), .dot(dot), .busy(busy), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        m_done = 0;
        if (rst) begin
            m_kind = 0; m_rem = 0; m_pend = 0; m_psel = 0;
            m_bin = '0; m_sgn = 1'b0; m_dot = '0;
        end else if (clr) begin
            m_kind = 0; m_rem = 0; m_pend = 0; m_psel = 0;
            m_bin = '0; m_sgn = 1'b0; m_dot = '0;
        end else begin
            if (num_we) begin
                m_bin = bin_in; m_sgn = sgn_in; m_dot = dot_in;
            end
            if (err_req) begin
                if (prompt_req) begin m_pend = 1; m_psel = prompt_sel; end
                m_kind = 3; m_rem = HOLD;
            end else if (prompt_req && m_kind != 3) begin
                m_kind = prompt_sel ? 2 : 1; m_rem = HOLD;
            end else begin
                if (prompt_req) begin m_pend = 1; m_psel = prompt_sel; end
                if (m_kind != 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1;
                        if (m_kind == 3 && m_pend) begin
                            m_kind = m_psel ? 2 : 1; m_rem = HOLD; m_pend = 0;
                        end else begin
                            m_kind = 0;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, settle, drop pulses
    task automatic cyc(input logic r, c, e, p, ps, we, input logic [7:0] b,
                       input logic s, input logic [1:0] d);
        rst = r; clr = c; err_req = e; prompt_req = p; prompt_sel = ps;
        num_we = we; bin_in = b; sgn_in = s; dot_in = d;
        @(posedge clk);
        model_step();
        #1;
        rst = 0; clr = 0; err_req = 0; prompt_req = 0; num_we = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, bin_in, sgn_in, dot_in);
    endtask

    task automatic test_reset();
        cyc(1, 0, 1, 1, 1, 1, 8'hFF, 1, 2'd3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({msg, bin, sgn, dot, busy, msg_done} !== 14'd0) begin
            errors++;
            $display("FAIL reset: got msg=%0d bin=%0d sgn=%0d dot=%0d busy=%0d done=%0d expected all 0",
                     msg, bin, sgn, dot, busy, msg_done);
        end
    endtask

    task automatic test_num_load();
        cyc(0, 0, 0, 0, 0, 1, 8'd123, 1, 2'd2);
        checks++;
        if (bin !== 8'd123 || sgn !== 1'b1 || dot !== 2'd2 || msg !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL num_load: got bin=%0d sgn=%0d dot=%0d msg=%0d busy=%0d expected 123 1 2 0 0",
                     bin, sgn, dot, msg, busy);
        end
    endtask

    task automatic test_err();
        cyc(0, 0, 1, 0, 0, 0, bin_in, sgn_in, dot_in);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (msg !== 2'b11 || busy !== 1'b1 || msg_done !== 1'b0) begin
                errors++;
                $display("FAIL err_hold k+%0d: got msg=%0d busy=%0d done=%0d expected 3 1 0", i, msg, busy, msg_done);
            end
            idle();
        end
        checks++;
        if (msg !== 2'b00 || busy !== 1'b0 || msg_done !== 1'b1) begin
            errors++;
            $display("FAIL err_expire: got msg=%0d busy=%0d done=%0d expected 0 0 1", msg, busy, msg_done);
        end
        idle();
        checks++;
        if (msg_done !== 1'b0) begin
            errors++;
            $display("FAIL err_done_width: got done=%0d expected 0", msg_done);
        end
    endtask

    task automatic test_err_prompt();
        cyc(0, 0, 1, 1, 1, 0, bin_in, sgn_in, dot_in);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (msg !== 2'b11 || msg_done !== 1'b0) begin
                errors++;
                $display("FAIL errprompt_err k+%0d: got msg=%0d done=%0d expected 3 0", i, msg, msg_done);
            end
            idle();
        end
        for (int i = 5; i <= 8; i++) begin
            checks++;
            if (msg !== 2'b10 || busy !== 1'b1 || msg_done !== (i == 5)) begin
                errors++;
                $display("FAIL errprompt_val k+%0d: got msg=%0d busy=%0d done=%0d expected 2 1 %0d",
                         i, msg, busy, msg_done, (i == 5));
            end
            idle();
        end
        checks++;
        if (msg !== 2'b00 || msg_done !== 1'b1) begin
            errors++;
            $display("FAIL errprompt_end: got msg=%0d done=%0d expected 0 1", msg, msg_done);
        end
        idle();
    endtask

    task automatic test_prompt_then_err();
        cyc(0, 0, 0, 1, 0, 0, bin_in, sgn_in, dot_in);
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if (msg !== 2'b01) begin
                errors++;
                $display("FAIL prompt_op k+%0d: got msg=%0d expected 1", i, msg);
            end
            if (i == 1) idle();
        end
        cyc(0, 0, 1, 0, 0, 0, bin_in, sgn_in, dot_in);
        for (int i = 3; i <= 6; i++) begin
            checks++;
            if (msg !== 2'b11) begin
                errors++;
                $display("FAIL prompt_err k+%0d: got msg=%0d expected 3", i, msg);
            end
            idle();
        end
        checks++;
        if (msg !== 2'b00 || msg_done !== 1'b1) begin
            errors++;
            $display("FAIL prompt_err_end: got msg=%0d done=%0d expected 0 1", msg, msg_done);
        end
        idle();
        checks++;
        if (msg !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL prompt_no_resume: got msg=%0d busy=%0d expected 0 0", msg, busy);
        end
    endtask

    task automatic test_err_restart();
        cyc(0, 0, 1, 0, 0, 0, bin_in, sgn_in, dot_in);
        idle();
        idle();
        cyc(0, 0, 1, 0, 0, 0, bin_in, sgn_in, dot_in);
        for (int i = 4; i <= 7; i++) begin
            checks++;
            if (msg !== 2'b11 || msg_done !== 1'b0) begin
                errors++;
                $display("FAIL restart_hold k+%0d: got msg=%0d done=%0d expected 3 0", i, msg, msg_done);
            end
            idle();
        end
        checks++;
        if (msg !== 2'b00 || msg_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_end: got msg=%0d done=%0d expected 0 1", msg, msg_done);
        end
        idle();
    endtask

    task automatic test_clr();
        cyc(0, 0, 1, 0, 0, 0, bin_in, sgn_in, dot_in);
        idle();
        cyc(0, 0, 0, 0, 0, 1, 8'd45, 0, 2'd0);
        checks++;
        if (bin !== 8'd45 || msg !== 2'b11) begin
            errors++;
            $display("FAIL clr_pre: got bin=%0d msg=%0d expected 45 3", bin, msg);
        end
        cyc(0, 1, 0, 0, 0, 0, bin_in, sgn_in, dot_in);
        checks++;
        if (msg !== 2'b00 || bin !== 8'd0 || msg_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_post: got msg=%0d bin=%0d done=%0d busy=%0d expected 0 0 0 0",
                     msg, bin, msg_done, busy);
        end
        for (int i = 0; i < HOLD + 1; i++) begin
            idle();
            checks++;
            if (msg_done !== 1'b0 || msg !== 2'b00) begin
                errors++;
                $display("FAIL clr_quiet %0d: got done=%0d msg=%0d expected 0 0", i, msg_done, msg);
            end
        end
        cyc(0, 1, 0, 0, 0, 1, 8'd99, 1, 2'd3);
        checks++;
        if (bin !== 8'd0 || sgn !== 1'b0 || dot !== 2'd0) begin
            errors++;
            $display("FAIL clr_with_we: got bin=%0d sgn=%0d dot=%0d expected 0 0 0", bin, sgn, dot);
        end
    endtask

    task automatic test_rst_mid();
        cyc(0, 0, 0, 0, 0, 1, 8'd77, 1, 2'd1);
        cyc(0, 0, 1, 1, 1, 0, bin_in, sgn_in, dot_in);
        idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * HOLD + 2; i++) begin
            checks++;
            if ({msg, bin, sgn, dot, busy, msg_done} !== 14'd0) begin
                errors++;
                $display("FAIL rst_mid %0d: got msg=%0d bin=%0d sgn=%0d dot=%0d busy=%0d done=%0d expected all 0",
                         i, msg, bin, sgn, dot, busy, msg_done);
            end
            idle();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 14) == 0), ($urandom_range(0, 9) == 0),
                1'($urandom), ($urandom_range(0, 3) == 0),
                8'($urandom), 1'($urandom), 2'($urandom));
            checks++;
            if (msg !== 2'(m_kind) || busy !== (m_kind != 0) || msg_done !== m_done ||
                bin !== m_bin || sgn !== m_sgn || dot !== m_dot) begin
                errors++;
                $display("FAIL random n=%0d: got msg=%0d busy=%0d done=%0d bin=%0d sgn=%0d dot=%0d expected %0d %0d %0d %0d %0d %0d",
                         n, msg, busy, msg_done, bin, sgn, dot,
                         m_kind, (m_kind != 0), m_done, m_bin, m_sgn, m_dot);
            end
        end
    endtask

    initial begin
        test_reset();
        test_num_load();
        test_err();
        test_err_prompt();
        test_prompt_then_err();
        test_err_restart();
        test_clr();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
